// File: rtl/bram_port_arbiter.sv
// Round-robin (with burst lock) sharer of BRAM port B; one accept per cycle, port driven the cycle after accept.
// Read data returns RD_LAT+1 cycles after accept with a one-hot RVALID; losers simply keep REQ high.
module bram_port_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 13,
   parameter int DW     = 32,
   parameter int RD_LAT = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ-1:0]      WE,
   input  logic [NREQ*AW-1:0]   ADDR,
   input  logic [NREQ*DW-1:0]   WDATA,
   input  logic [NREQ-1:0]      LOCK,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      RVALID,
   output logic [DW-1:0]        RDATA,
   output logic                 BUSY,
   output logic [AW-1:0]        addrb,
   output logic [DW-1:0]        dinb,
   input  logic [DW-1:0]        doutb,
   output logic                 enb,
   output logic [DW/8-1:0]      web
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]              ptr_q, ptr_d;
   logic                       enb_q, enb_d;
   logic [DW/8-1:0]            web_q, web_d;
   logic [AW-1:0]              addrb_q, addrb_d;
   logic [DW-1:0]              dinb_q, dinb_d;
   logic [RD_LAT-1:0]          tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0][PW-1:0]  tag_idx_q, tag_idx_d;
   logic [NREQ-1:0]            rvalid_q, rvalid_d;
   logic [DW-1:0]              rdata_q, rdata_d;

   logic [NREQ-1:0]            gnt;
   logic [PW-1:0]              sel;
   logic [PW-1:0]              cand;
   logic                       found;
   logic                       acc;
   logic [AW-1:0]              addr_a  [NREQ];
   logic [DW-1:0]              wdata_a [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i]  = ADDR[i*AW +: AW];
         wdata_a[i] = WDATA[i*DW +: DW];
      end
   end

   // first requester at or after the pointer, wrapping
   always_comb begin
      gnt   = '0;
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!found && REQ[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      if (found && !RST) gnt[sel] = 1'b1;
      acc = |gnt;
   end

   always_comb begin
      ptr_d   = ptr_q;
      enb_d   = acc;
      web_d   = '0;
      addrb_d = addrb_q;
      dinb_d  = dinb_q;
      if (acc) begin
         ptr_d   = LOCK[sel] ? sel : ((sel == PW'(NREQ-1)) ? '0 : sel + PW'(1));
         web_d   = WE[sel] ? '1 : '0;
         addrb_d = addr_a[sel];
         dinb_d  = wdata_a[sel];
      end
   end

   always_comb begin
      tag_vld_d    = '0;
      tag_idx_d    = '0;
      tag_vld_d[0] = acc & ~WE[sel];
      tag_idx_d[0] = sel;
      for (int s = 1; s < RD_LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_idx_d[s] = tag_idx_q[s-1];
      end
      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (tag_vld_q[RD_LAT-1]) begin
         rvalid_d[tag_idx_q[RD_LAT-1]] = 1'b1;
         rdata_d = doutb;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q     <= '0;
         enb_q     <= 1'b0;
         web_q     <= '0;
         addrb_q   <= '0;
         dinb_q    <= '0;
         tag_vld_q <= '0;
         tag_idx_q <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         enb_q     <= enb_d;
         web_q     <= web_d;
         addrb_q   <= addrb_d;
         dinb_q    <= dinb_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign GNT    = gnt;
   assign RVALID = rvalid_q;
   assign RDATA  = rdata_q;
   assign BUSY   = enb_q | (|tag_vld_q);
   assign addrb  = addrb_q;
   assign dinb   = dinb_q;
   assign enb    = enb_q;
   assign web    = web_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first BRAM model on port B.
module tb_bram_port_arbiter;
   logic         CLK;
   logic         RST;
   logic [3:0]   REQ, WE, LOCK;
   logic [51:0]  ADDR;
   logic [127:0] WDATA;
   logic [3:0]   GNT, RVALID;
   logic [31:0]  RDATA;
   logic         BUSY;
   logic [12:0]  addrb;
   logic [31:0]  dinb;
   logic [31:0]  doutb;
   logic         enb;
   logic [3:0]   web;

   int checks = 0;
   int errors = 0;

   bram_port_arbiter #(.NREQ(4), .AW(13), .DW(32), .RD_LAT(2)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
      .LOCK(LOCK), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .BUSY(BUSY),
      .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] mem [0:8191];
   always @(posedge CLK) begin
      if (enb) begin
         if (web == 4'hF) begin
            mem[addrb] <= dinb;
            doutb      <= dinb;
         end else begin
            doutb <= mem[addrb];
         end
      end
   end

   typedef struct {
      logic        rst;
      logic [3:0]  req, we, lock;
      logic [12:0] addr;
      logic [31:0] wdata;
      logic [3:0]  gnt;
      logic        enb;
      logic [3:0]  web;
      logic [12:0] addrb;
      logic [31:0] dinb;
      logic [3:0]  rvalid;
      logic [31:0] rdata;
      logic        busy;
   } vec_t;

   vec_t tbl [27];

   function automatic vec_t v(input logic rst, input logic [3:0] req, we, lock,
                              input logic [12:0] addr, input logic [31:0] wdata,
                              input logic [3:0] gnt, input logic en, input logic [3:0] wb,
                              input logic [12:0] ab, input logic [31:0] db,
                              input logic [3:0] rv, input logic [31:0] rd, input logic bz);
      vec_t r;
      r.rst = rst; r.req = req; r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
      r.gnt = gnt; r.enb = en; r.web = wb; r.addrb = ab; r.dinb = db;
      r.rvalid = rv; r.rdata = rd; r.busy = bz;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      RST = 1'b1; REQ = '0; WE = '0; LOCK = '0; ADDR = '0; WDATA = '0;

      //            rst req  we   lock addr     wdata          gnt  enb web  addrb    dinb           rvalid rdata          busy
      tbl[0]  = v(1, 4'hF, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);
      tbl[1]  = v(1, 4'hF, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);
      tbl[2]  = v(0, 4'h2, 4'hF, 4'h0, 13'h0A5, 32'hDEADBEEF, 4'h2, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);
      tbl[3]  = v(0, 4'h4, 4'h0, 4'h0, 13'h0A5, 32'h11111111, 4'h4, 1, 4'hF, 13'h0A5, 32'hDEADBEEF, 4'h0, 32'h0,        1);
      tbl[4]  = v(0, 4'h0, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h0, 1, 4'h0, 13'h0A5, 32'h11111111, 4'h0, 32'h0,        1);
      tbl[5]  = v(0, 4'h0, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h0, 0, 4'h0, 13'h0A5, 32'h11111111, 4'h0, 32'h0,        1);
      tbl[6]  = v(0, 4'h0, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h0, 0, 4'h0, 13'h0A5, 32'h11111111, 4'h4, 32'hDEADBEEF, 0);
      tbl[7]  = v(0, 4'h8, 4'hF, 4'h0, 13'h010, 32'hCAFE0003, 4'h8, 0, 4'h0, 13'h0A5, 32'h11111111, 4'h0, 32'hDEADBEEF, 0);
      tbl[8]  = v(0, 4'hF, 4'h0, 4'h0, 13'h010, 32'h0,        4'h1, 1, 4'hF, 13'h010, 32'hCAFE0003, 4'h0, 32'hDEADBEEF, 1);
      tbl[9]  = v(0, 4'hF, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h2, 1, 4'h0, 13'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1);
      tbl[10] = v(0, 4'hF, 4'h0, 4'h0, 13'h010, 32'h0,        4'h4, 1, 4'h0, 13'h0A5, 32'h0,        4'h0, 32'hDEADBEEF, 1);
      tbl[11] = v(0, 4'hF, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h8, 1, 4'h0, 13'h010, 32'h0,        4'h1, 32'hCAFE0003, 1);
      tbl[12] = v(0, 4'hF, 4'h0, 4'h1, 13'h010, 32'h0,        4'h1, 1, 4'h0, 13'h0A5, 32'h0,        4'h2, 32'hDEADBEEF, 1);
      tbl[13] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 1, 4'h0, 13'h010, 32'h0,        4'h4, 32'hCAFE0003, 1);
      tbl[14] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h010, 32'h0,        4'h8, 32'hDEADBEEF, 1);
      tbl[15] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h010, 32'h0,        4'h1, 32'hCAFE0003, 0);
      tbl[16] = v(0, 4'h5, 4'hF, 4'h1, 13'h020, 32'hA0000001, 4'h1, 0, 4'h0, 13'h010, 32'h0,        4'h0, 32'hCAFE0003, 0);
      tbl[17] = v(0, 4'h5, 4'hF, 4'h1, 13'h021, 32'hA0000002, 4'h1, 1, 4'hF, 13'h020, 32'hA0000001, 4'h0, 32'hCAFE0003, 1);
      tbl[18] = v(0, 4'h5, 4'hF, 4'h0, 13'h022, 32'hA0000003, 4'h1, 1, 4'hF, 13'h021, 32'hA0000002, 4'h0, 32'hCAFE0003, 1);
      tbl[19] = v(0, 4'h5, 4'hF, 4'h0, 13'h023, 32'hA0000004, 4'h4, 1, 4'hF, 13'h022, 32'hA0000003, 4'h0, 32'hCAFE0003, 1);
      tbl[20] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 1, 4'hF, 13'h023, 32'hA0000004, 4'h0, 32'hCAFE0003, 1);
      tbl[21] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h023, 32'hA0000004, 4'h0, 32'hCAFE0003, 0);
      tbl[22] = v(0, 4'h8, 4'h0, 4'h0, 13'h0A5, 32'h0,        4'h8, 0, 4'h0, 13'h023, 32'hA0000004, 4'h0, 32'hCAFE0003, 0);
      tbl[23] = v(1, 4'h2, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 1, 4'h0, 13'h0A5, 32'h0,        4'h0, 32'hCAFE0003, 1);
      tbl[24] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);
      tbl[25] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);
      tbl[26] = v(0, 4'h0, 4'h0, 4'h0, 13'h000, 32'h0,        4'h0, 0, 4'h0, 13'h000, 32'h0,        4'h0, 32'h0,        0);

      for (int n = 0; n < 27; n++) begin
         @(negedge CLK);
         RST   = tbl[n].rst;
         REQ   = tbl[n].req;
         WE    = tbl[n].we;
         LOCK  = tbl[n].lock;
         ADDR  = {4{tbl[n].addr}};
         WDATA = {4{tbl[n].wdata}};
         #1;
         chk($sformatf("row%0d gnt", n),    32'(GNT),    32'(tbl[n].gnt));
         chk($sformatf("row%0d enb", n),    32'(enb),    32'(tbl[n].enb));
         chk($sformatf("row%0d web", n),    32'(web),    32'(tbl[n].web));
         chk($sformatf("row%0d addrb", n),  32'(addrb),  32'(tbl[n].addrb));
         chk($sformatf("row%0d dinb", n),   dinb,        tbl[n].dinb);
         chk($sformatf("row%0d rvalid", n), 32'(RVALID), 32'(tbl[n].rvalid));
         chk($sformatf("row%0d rdata", n),  RDATA,       tbl[n].rdata);
         chk($sformatf("row%0d busy", n),   32'(BUSY),   32'(tbl[n].busy));
      end

      // waiting requester 1 changes its address before it is granted
      @(negedge CLK);
      REQ = 4'b0011; WE = 4'h0; LOCK = 4'h0;
      ADDR = {13'h000, 13'h000, 13'h0A5, 13'h020};
      #1;
      chk("hold gnt0", 32'(GNT), 32'h1);
      @(negedge CLK);
      REQ = 4'b0010;
      ADDR = {13'h000, 13'h000, 13'h021, 13'h020};
      #1;
      chk("hold gnt1", 32'(GNT), 32'h2);
      chk("hold addrb0", 32'(addrb), 32'h020);
      @(negedge CLK);
      REQ = 4'h0;
      #1;
      chk("hold addrb1", 32'(addrb), 32'h021);
      chk("hold rvalid early", 32'(RVALID), 32'h0);
      @(negedge CLK);
      #1;
      chk("hold rvalid0", 32'(RVALID), 32'h1);
      chk("hold rdata0", RDATA, 32'hA0000001);
      @(negedge CLK);
      #1;
      chk("hold rvalid1", 32'(RVALID), 32'h2);
      chk("hold rdata1", RDATA, 32'hA0000002);
      @(negedge CLK);
      #1;
      chk("hold rvalid end", 32'(RVALID), 32'h0);
      chk("hold rdata keep", RDATA, 32'hA0000002);
      chk("hold busy end", 32'(BUSY), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
